// File: rtl/worker_responder.sv
// Worker on a shared server bus: FIFO-backed write port and a fixed-latency read
// responder that returns (FIFO head + ID). Bus outputs are zero whenever idle.
module worker_responder #(
  parameter int ID    = 1,
  parameter int DEPTH = 4,
  parameter int LAT   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              id,
  input  logic                    read,
  output logic                    rready,
  output logic [31:0]             rdata,
  input  logic                    write,
  output logic                    wready,
  input  logic [31:0]             wdata,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_s;
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [LW-1:0]   level_r;
  logic [31:0]     mem_r [DEPTH];

  logic            sel_s;
  logic            accept_s;
  logic            empty_s;
  logic            full_s;
  logic            push_s;
  logic            pop_s;
  logic            wready_s;
  logic            rready_s;
  logic [31:0]     rdata_s;

  // Pointers wrap naturally because DEPTH is a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
    return ptr + AW'(1);
  endfunction

  assign sel_s    = (id == 3'(ID));
  assign accept_s = (state_r == IDLE) && read && sel_s;
  assign empty_s  = (level_r == LW'(0));
  assign full_s   = (level_r >= LW'(DEPTH));
  assign wready_s = sel_s && (state_r == IDLE) && !(read && sel_s) && !full_s;
  assign push_s   = write && wready_s;
  assign pop_s    = (state_r == RESP) && !empty_s;

  assign wready = wready_s;
  assign rready = rready_s;
  assign rdata  = rdata_s;
  assign level  = level_r;

  // Read-response drive: only RESP puts anything on the shared bus.
  always_comb begin
    rready_s = 1'b0;
    rdata_s  = 32'h0000_0000;
    if (state_r == RESP) begin
      rready_s = 1'b1;
      if (empty_s) begin
        rdata_s = 32'hFFFF_FFFF;
      end else begin
        rdata_s = mem_r[rd_ptr_r] + 32'(ID);
      end
    end else begin
      rready_s = 1'b0;
      rdata_s  = 32'h0000_0000;
    end
  end

  // Next-state and latency counter logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = BUSY;
          cnt_s   = CW'(LAT - 1);
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == CW'(0)) begin
          state_s = RESP;
        end else begin
          cnt_s = cnt_r - CW'(1);
        end
      end
      RESP: begin
        state_s = DRAIN;
      end
      DRAIN: begin
        // Wait for the server to drop the held read so it is not re-accepted.
        if (!read || !sel_s) begin
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CW'(0);
      end
    endcase
  end

  // FSM, counter, FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      cnt_r    <= CW'(0);
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      level_r  <= LW'(0);
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // FIFO storage; contents are unobservable after reset so they are not cleared.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

endmodule

// File: tb/tb_worker_responder.sv
// Self-checking bench for worker_responder: vector table, directed corner cases,
// and random traffic checked against a queue/timeline reference model.
module tb_worker_responder;

  localparam int ID    = 1;
  localparam int DEPTH = 4;
  localparam int LAT   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  id;
  logic        read;
  logic        rready;
  logic [31:0] rdata;
  logic        write;
  logic        wready;
  logic [31:0] wdata;
  logic [2:0]  level;

  worker_responder #(.ID(ID), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .id(id), .read(read), .rready(rready), .rdata(rdata),
    .write(write), .wready(wready), .wdata(wdata), .level(level)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  // Reference model: FIFO contents, the cycle at which a response is due,
  // and whether a served read is still being held by the server.
  bit [31:0] mq[$];
  int        resp_at  = -1;
  bit        draining = 1'b0;
  int        cyc      = 0;

  logic        obs_rready;
  logic [31:0] obs_rdata;
  logic        obs_wready;
  logic [2:0]  obs_level;

  typedef struct {
    bit        r;
    bit [2:0]  i;
    bit        rd;
    bit        wr;
    bit [31:0] wd;
    bit        e_rr;
    bit        e_wrdy;
    bit [31:0] e_rdata;
    bit [2:0]  e_lvl;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One bus cycle: apply inputs, compare against the model, then advance past the edge.
  task automatic drive(input bit r, input bit [2:0] i, input bit rd, input bit wr, input bit [31:0] wd);
    bit        m_sel;
    bit        m_idle;
    bit        e_rr;
    bit [31:0] e_rd;
    bit        e_wr;
    rst = r; id = i; read = rd; write = wr; wdata = wd;
    #1;
    obs_rready = rready; obs_rdata = rdata; obs_wready = wready; obs_level = level;
    m_sel  = (i == 3'(ID));
    m_idle = (resp_at < 0) && !draining;
    e_rr   = (cyc == resp_at);
    e_rd   = 32'h0;
    if (e_rr) e_rd = (mq.size() > 0) ? mq[0] + 32'(ID) : 32'hFFFF_FFFF;
    e_wr   = m_sel && m_idle && !(rd && m_sel) && (mq.size() < DEPTH);
    if (check_en) begin
      check("m_rready", obs_rready, 32'(e_rr));
      check("m_rdata", obs_rdata, e_rd);
      check("m_wready", obs_wready, 32'(e_wr));
      check("m_level", 32'(obs_level), 32'(mq.size()));
    end
    @(posedge clk);
    if (r) begin
      mq.delete();
      resp_at  = -1;
      draining = 1'b0;
    end else begin
      if (e_wr && wr) mq.push_back(wd);
      if (e_rr) begin
        if (mq.size() > 0) void'(mq.pop_front());
        resp_at  = -1;
        draining = 1'b1;
      end else if (draining) begin
        if (!rd || !m_sel) draining = 1'b0;
      end else if (m_idle && rd && m_sel) begin
        resp_at = cyc + LAT + 1;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic reset_dut();
    drive(1'b1, 3'd2, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 3'd2, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_read(input bit [31:0] exp, input string nm);
    bit got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      drive(1'b0, 3'd1, 1'b1, 1'b0, 32'h0);
      if (obs_rready) begin
        got = 1'b1;
        check({nm, "_rdata"}, obs_rdata, exp);
      end
    end
    check({nm, "_seen"}, 32'(got), 32'd1);
    drive(1'b0, 3'd1, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; id = 3'd0; read = 1'b0; write = 1'b0; wdata = 32'h0;
    @(posedge clk);
    #1;
    reset_dut();
    check_en = 1'b1;

    // Reset state.
    drive(1'b0, 3'd2, 1'b0, 1'b0, 32'h0);
    check("rst_rready", obs_rready, 32'd0);
    check("rst_level", 32'(obs_level), 32'd0);

    // Three writes then a read held until the response.
    tbl[0]  = '{1'b0, 3'd1, 1'b0, 1'b1, 32'd10, 1'b0, 1'b1, 32'd0,  3'd0};
    tbl[1]  = '{1'b0, 3'd1, 1'b0, 1'b1, 32'd20, 1'b0, 1'b1, 32'd0,  3'd1};
    tbl[2]  = '{1'b0, 3'd1, 1'b0, 1'b1, 32'd30, 1'b0, 1'b1, 32'd0,  3'd2};
    tbl[3]  = '{1'b0, 3'd1, 1'b0, 1'b0, 32'd0,  1'b0, 1'b1, 32'd0,  3'd3};
    tbl[4]  = '{1'b0, 3'd1, 1'b1, 1'b0, 32'd0,  1'b0, 1'b0, 32'd0,  3'd3};
    tbl[5]  = '{1'b0, 3'd1, 1'b1, 1'b0, 32'd0,  1'b0, 1'b0, 32'd0,  3'd3};
    tbl[6]  = '{1'b0, 3'd1, 1'b1, 1'b0, 32'd0,  1'b0, 1'b0, 32'd0,  3'd3};
    tbl[7]  = '{1'b0, 3'd1, 1'b1, 1'b0, 32'd0,  1'b0, 1'b0, 32'd0,  3'd3};
    tbl[8]  = '{1'b0, 3'd1, 1'b1, 1'b0, 32'd0,  1'b0, 1'b0, 32'd0,  3'd3};
    tbl[9]  = '{1'b0, 3'd1, 1'b1, 1'b0, 32'd0,  1'b1, 1'b0, 32'd11, 3'd3};
    tbl[10] = '{1'b0, 3'd1, 1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 32'd0,  3'd2};
    tbl[11] = '{1'b0, 3'd1, 1'b0, 1'b0, 32'd0,  1'b0, 1'b1, 32'd0,  3'd2};
    for (int k = 0; k < 12; k++) begin
      drive(tbl[k].r, tbl[k].i, tbl[k].rd, tbl[k].wr, tbl[k].wd);
      check($sformatf("tbl%0d_rready", k), obs_rready, 32'(tbl[k].e_rr));
      check($sformatf("tbl%0d_wready", k), obs_wready, 32'(tbl[k].e_wrdy));
      check($sformatf("tbl%0d_rdata", k), obs_rdata, tbl[k].e_rdata);
      check($sformatf("tbl%0d_level", k), 32'(obs_level), 32'(tbl[k].e_lvl));
    end

    // Full FIFO rejects a fifth write, then drains in order.
    reset_dut();
    for (int k = 1; k <= 4; k++) drive(1'b0, 3'd1, 1'b0, 1'b1, 32'(k));
    drive(1'b0, 3'd1, 1'b0, 1'b1, 32'd5);
    check("full_wready", obs_wready, 32'd0);
    drive(1'b0, 3'd1, 1'b0, 1'b0, 32'd0);
    check("full_level", 32'(obs_level), 32'd4);
    for (int k = 1; k <= 4; k++) do_read(32'(k + 1), "full_rd");
    drive(1'b0, 3'd1, 1'b0, 1'b0, 32'd0);
    check("drained_level", 32'(obs_level), 32'd0);

    // Empty read, then read held through DRAIN.
    reset_dut();
    begin
      bit got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        drive(1'b0, 3'd1, 1'b1, 1'b0, 32'h0);
        if (obs_rready) begin
          got = 1'b1;
          check("empty_rdata", obs_rdata, 32'hFFFF_FFFF);
        end
      end
      check("empty_seen", 32'(got), 32'd1);
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 3'd1, 1'b1, 1'b0, 32'h0);
      check("held_rready", obs_rready, 32'd0);
    end
    drive(1'b0, 3'd1, 1'b0, 1'b0, 32'h0);
    check("drain_wready", obs_wready, 32'd0);
    drive(1'b0, 3'd1, 1'b0, 1'b0, 32'h0);
    check("idle_wready", obs_wready, 32'd1);
    check("empty_level", 32'(obs_level), 32'd0);

    // Foreign id keeps the bus quiet; simultaneous read/write favours read.
    drive(1'b0, 3'd1, 1'b0, 1'b1, 32'd7);
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 3'd2, 1'b1, 1'b1, 32'(k));
      check("other_bus", {obs_rdata[31:2], obs_rdata[1:0] | {obs_rready, obs_wready}}, 32'd0);
      check("other_level", 32'(obs_level), 32'd1);
    end
    drive(1'b0, 3'd1, 1'b1, 1'b1, 32'd99);
    check("rw_wready", obs_wready, 32'd0);
    do_read(32'd8, "rw_rd");
    drive(1'b0, 3'd1, 1'b0, 1'b0, 32'd0);
    check("rw_level", 32'(obs_level), 32'd0);

    // Reset two cycles after a read is accepted.
    drive(1'b0, 3'd1, 1'b0, 1'b1, 32'd5);
    drive(1'b0, 3'd1, 1'b1, 1'b0, 32'd0);
    drive(1'b0, 3'd1, 1'b1, 1'b0, 32'd0);
    drive(1'b0, 3'd1, 1'b1, 1'b0, 32'd0);
    drive(1'b1, 3'd1, 1'b1, 1'b0, 32'd0);
    drive(1'b0, 3'd1, 1'b0, 1'b1, 32'd77);
    check("post_rst_level", 32'(obs_level), 32'd0);
    check("post_rst_wready", obs_wready, 32'd1);
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 3'd1, 1'b0, 1'b0, 32'd0);
      check("abort_rready", obs_rready, 32'd0);
    end
    do_read(32'd78, "post_rst_rd");

    // Pointer wrap across nine push/pop pairs.
    for (int k = 0; k < 9; k++) begin
      drive(1'b0, 3'd1, 1'b0, 1'b1, 32'(100 + k));
      do_read(32'(101 + k), "wrap_rd");
    end

    // Random traffic against the model.
    reset_dut();
    for (int k = 0; k < 400; k++) begin
      bit [2:0] ri;
      ri = ($urandom_range(0, 3) != 0) ? 3'd1 : 3'($urandom_range(0, 7));
      drive(($urandom_range(0, 59) == 0), ri, ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 1) == 1), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/worker_responder.md
WORKER_RESPONDER -- requirements
Module: worker_responder

Interface
REQ-001 Parameter ID, default 1: worker address; a request is addressed to this worker when id == ID.
REQ-002 Parameter DEPTH, default 4: entries in the write FIFO; power of two, at least 2.
REQ-003 Parameter LAT, default 4: compute latency in cycles; at least 1.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 id  input  3  worker select driven by the server; shared by all workers.
REQ-007 read  input  1  server read request; held high until rready is seen.
REQ-008 rready  output  1  one-cycle read-response strobe.
REQ-009 rdata  output  32  read response data.
REQ-010 write  input  1  server write request.
REQ-011 wready  output  1  write accept; a transfer occurs in any cycle where write && wready.
REQ-012 wdata  input  32  write data.
REQ-013 level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-014 sel = (id == ID); rready, rdata and wready are shared-bus outputs and SHALL be 0 whenever this worker is not driving them, so the server can OR-combine workers.
REQ-015 The FSM has 4 states: IDLE, BUSY, RESP, DRAIN.
REQ-016 In IDLE, read && sel SHALL move the FSM to BUSY and load the down-counter cnt with LAT-1; this is the accept edge E0.
REQ-017 In BUSY, cnt decrements each edge; at the edge where cnt == 0 the FSM moves to RESP.
REQ-018 In RESP, rready = 1 for exactly one cycle; this is the cycle after edge E0+LAT.
REQ-019 In RESP with the FIFO non-empty, rdata = (FIFO head + ID) mod 2^32, and the head pops on the edge leaving RESP.
REQ-020 In RESP with the FIFO empty, rdata = 32'hFFFF_FFFF and nothing pops.
REQ-021 On leaving RESP, the FSM goes to DRAIN; from DRAIN it goes to IDLE on the first edge where read == 0 or sel == 0, so a held read is never accepted twice.
REQ-022 Outside RESP, rready = 0 and rdata = 0.
REQ-023 wready = sel && state == IDLE && !(read && sel) && level < DEPTH (combinational).
REQ-024 Read wins over a simultaneous write in IDLE: wready = 0, the write is not taken, and the server retries it.
REQ-025 A transfer pushes wdata at the tail; wr/rd pointers wrap modulo DEPTH; level increments by 1 per push and decrements by 1 per pop.
REQ-026 A push and a pop never occur on the same edge, because wready = 0 outside IDLE.
REQ-027 When full (level == DEPTH), wready = 0; write is ignored and no data is overwritten.
REQ-028 wdata and id are sampled only on the transfer edge; values on other cycles are don't-care.

Reset
REQ-029 When rst = 1 at an edge: FSM to IDLE, cnt = 0, FIFO pointers and level = 0; from that cycle rready = 0, rdata = 0, and wready follows REQ-023 with level = 0.
REQ-030 Reset during BUSY or RESP SHALL abort the read with no pop and no rready pulse afterwards.
REQ-031 FIFO storage contents need not be cleared; they are unobservable after reset.

Verification (ID=1, LAT=4, DEPTH=4)
REQ-032 Write 10, 20, 30 to id=1, then read:
  - wready = 1 on each write; level reaches 3.
  - rready pulses once, in the cycle after edge E0+4, with rdata = 11.
  - level = 2 afterwards.
REQ-033 Fill 4 entries, then attempt a 5th write:
  - wready = 0; level stays 4.
  - Four subsequent reads return 2, 3, 4, 5 for data 1, 2, 3, 4, then level = 0.
REQ-034 Read on an empty FIFO:
  - rready pulses with rdata = 32'hFFFF_FFFF; level stays 0.
  - With read still held 3 cycles after rready: no second pulse; FSM leaves DRAIN only after read falls.
REQ-035 Wrong id and simultaneous requests:
  - id = 2 with read and write high for 20 cycles: rready, wready and rdata stay 0; level unchanged.
  - read and write both addressed to id=1 in IDLE: read accepted, wready = 0.
REQ-036 Reset mid-operation:
  - rst = 1 two cycles after a read is accepted: no rready pulse; level = 0.
  - A write the cycle after rst deasserts is accepted; a following read returns wdata + 1.
REQ-037 Pointer wrap: push/pop 9 words one at a time (data 100 to 108): each read returns data + 1 across pointer wrap.
